// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings.
// The sequencer uses the slave modport; whatever drives locked/restart uses master.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [2:0] retry_count;
  logic [7:0] lock_loss_count;

  modport master (
    output locked,
    output restart,
    input  pll_rst,
    input  sys_reset,
    input  ready,
    input  fault,
    input  state,
    input  retry_count,
    input  lock_loss_count
  );

  modport slave (
    input  locked,
    input  restart,
    output pll_rst,
    output sys_reset,
    output ready,
    output fault,
    output state,
    output retry_count,
    output lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable lock, releases the
// system reset, and re-sequences on lock loss until too many lock timeouts latch FAULT.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned CNT_WIDTH     = 17
) (
  input  logic                  clock,
  input  logic                  reset,
  pll_reset_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_LOST      = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  localparam int unsigned GW = $clog2(GLITCH_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0]        GLITCH_LAST  = GW'(GLITCH_CYCLES - 1);
  localparam logic [2:0]           RETRY_LAST   = 3'(MAX_RETRIES - 1);

  logic                 lock_meta_q;
  logic                 lock_s_q;
  state_e               state_q,  state_d;
  logic [CNT_WIDTH-1:0] timer_q,  timer_d;
  logic [GW-1:0]        glitch_q, glitch_d;
  logic [2:0]           retry_q,  retry_d;
  logic [7:0]           loss_q,   loss_d;
  logic                 pll_rst_q;
  logic                 sys_reset_q;
  logic                 ready_q;
  logic                 fault_q;
  logic                 timed_state;

  // Only the timed states need the shared timer; elsewhere it is held at zero.
  assign timed_state = (state_q == S_PLL_RESET) || (state_q == S_WAIT_LOCK) ||
                       (state_q == S_STABLE);

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    glitch_d = '0;
    timer_d  = '0;

    if (bus.restart) begin
      state_d = S_PLL_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        S_PLL_RESET: begin
          if (timer_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
          end else if (timer_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 3'd1;
            state_d = (retry_q == RETRY_LAST) ? S_FAULT : S_PLL_RESET;
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN: begin
          // Short lock dropouts are filtered; only a sustained low is a loss.
          if (!lock_s_q) begin
            if (glitch_q == GLITCH_LAST) begin
              state_d = S_LOST;
              if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
              end
            end else begin
              glitch_d = glitch_q + GW'(1);
            end
          end
        end
        S_LOST: begin
          state_d = S_PLL_RESET;
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_PLL_RESET;
        end
      endcase
    end

    if (!bus.restart && (state_d == state_q) && timed_state) begin
      timer_d = timer_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_PLL_RESET;
      timer_q     <= '0;
      glitch_q    <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      lock_meta_q <= bus.locked;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      glitch_q    <= glitch_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      // Outputs decode the next state so they switch on the same edge as state_q.
      pll_rst_q   <= (state_d == S_PLL_RESET) || (state_d == S_FAULT);
      sys_reset_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.sys_reset       = sys_reset_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.state           = state_q;
  assign bus.retry_count     = retry_q;
  assign bus.lock_loss_count = loss_q;

endmodule
